// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stop levels, exception codes and FSM encoding for the pipeline controller
`ifndef PIPE_CTRL_STALL_DEF
`define PIPE_CTRL_STALL_DEF
`define Stall 5:0
`endif

package pipe_ctrl_pkg;
    localparam logic Stop = 1'b1;
    localparam logic NoStop = 1'b0;
    localparam int EXC_CODE_WIDTH = 5;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_None = 5'h10;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_Eret = 5'h11;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_e;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall requests, exception inputs and stall/flush outputs of the pipeline controller
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;
    logic                      stallreq_if;
    logic                      stallreq_id;
    logic                      stallreq_ex;
    logic                      stallreq_mem;
    logic                      ibus_busy;
    logic [EXC_CODE_WIDTH-1:0] exc_code_i;
    logic [31:0]               cp0_epc_i;
    logic [`Stall]             stall;
    logic                      flush;
    logic [31:0]               new_pc;
    logic                      stall_timeout;

    modport master (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, ibus_busy, exc_code_i, cp0_epc_i,
        output stall, flush, new_pc, stall_timeout
    );

    modport slave (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, ibus_busy, exc_code_i, cp0_epc_i,
        input  stall, flush, new_pc, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog: counts consecutive PC-stall cycles and raises a sticky timeout flag
module stall_watchdog #(
    parameter int               CNT_W         = 16,
    parameter logic [CNT_W-1:0] STALL_TIMEOUT = CNT_W'(1024)
) (
    input  logic cpu_clk_75M,
    input  logic cpu_rst_n,
    input  logic i_stall,
    output logic o_timeout
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_timeout;

    assign w_cnt_next = !i_stall ? '0 : (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign o_timeout  = r_timeout;

    // count stalled cycles (saturating) and latch the flag once the limit is reached
    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_timeout <= r_timeout | (w_cnt_next == STALL_TIMEOUT);
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall priority encoding, exception/ERET redirect sequencing and stall watchdog
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0]      EXC_VECTOR    = 32'hBFC0_0380,
    parameter int               CNT_W         = 16,
    parameter logic [CNT_W-1:0] STALL_TIMEOUT = CNT_W'(1024)
) (
    input  logic        cpu_clk_75M,
    input  logic        cpu_rst_n,
    pipe_ctrl_if.master bus
);
    state_e        r_state;
    state_e        w_state_next;
    logic [`Stall] w_stall;
    logic          w_exc;
    logic          w_flush_next;
    logic [31:0]   w_target;
    logic [31:0]   r_target;
    logic          r_flush;
    logic [31:0]   r_new_pc;

    assign w_exc        = bus.exc_code_i != EC_None;
    assign w_target     = (bus.exc_code_i == EC_Eret) ? bus.cp0_epc_i : EXC_VECTOR;
    assign w_flush_next = w_state_next == FLUSH;
    assign bus.stall    = w_stall;
    assign bus.flush    = r_flush;
    assign bus.new_pc   = r_new_pc;

    // state register
    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n)
            r_state <= RUN;
        else
            r_state <= w_state_next;
    end

    // next state and stall vector; a pending redirect freezes everything until the flush
    always_comb begin
        w_state_next = RUN;
        w_stall      = {6{NoStop}};
        case (r_state)
            RUN: begin
                if (w_exc) begin
                    w_stall      = {6{Stop}};
                    w_state_next = bus.ibus_busy ? DRAIN : FLUSH;
                end else begin
                    w_stall = bus.stallreq_mem ? 6'b011111 :
                              bus.stallreq_ex  ? 6'b001111 :
                              bus.stallreq_id  ? 6'b000111 :
                              bus.stallreq_if  ? 6'b000011 : 6'b000000;
                end
            end
            DRAIN: begin
                w_stall      = {6{Stop}};
                w_state_next = bus.ibus_busy ? DRAIN : FLUSH;
            end
            default: w_state_next = RUN;
        endcase
        if (!cpu_rst_n)
            w_stall = {6{NoStop}};
    end

    // capture the redirect target on acceptance and register the flush pulse with its PC
    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_target <= '0;
            r_flush  <= 1'b0;
            r_new_pc <= '0;
        end else begin
            if (r_state == RUN && w_exc)
                r_target <= w_target;
            r_flush  <= w_flush_next;
            r_new_pc <= w_flush_next ? ((r_state == RUN) ? w_target : r_target) : '0;
        end
    end

    stall_watchdog #(
        .CNT_W         (CNT_W),
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_watchdog (
        .cpu_clk_75M (cpu_clk_75M),
        .cpu_rst_n   (cpu_rst_n),
        .i_stall     (w_stall[0]),
        .o_timeout   (bus.stall_timeout)
    );
endmodule
